uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Serial UART receiver: the receive-side counterpart of the team's UART transmitter. It uses the same frame: start (0), 8 data bits LSB first, optional parity, stop (1); the line idles high.
- Oversamples rx_in at a runtime-selectable prescale, majority-votes each bit and checks start, parity and stop.
- Presents each good byte with a one-cycle valid pulse to the host-side logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- SYNC_STAGES, 2, flip-flops in the rx_in synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; runs prescale times faster than the baud rate.
- rst  input  1  reset, asynchronous, active-low.
- rx_in  input  1  asynchronous serial line; idles high.
- prescale  input  6  oversampling ratio; legal values 8, 16, 32.
- parity_en  input  1  1 means a parity bit follows the data bits.
- parity_type  input  1  0 selects even parity, 1 selects odd.
- p_data  output  DATA_WIDTH  last received byte.
- data_valid  output  1  one-cycle pulse; p_data holds a good byte.
- parity_error  output  1  one-cycle pulse on parity mismatch.
- stop_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high while a frame is being received.

Behaviour:
- Reset values:
  - all outputs 0, except p_data = 0 too; FSM in IDLE; counters 0.
  - Synchroniser flops reset to 1, so the line reads as idle.
- Synchroniser:
  - rx_in passes through SYNC_STAGES flops; all decisions use the synchronised rx_s.
  - Input-to-detection latency is SYNC_STAGES cycles.
- Counters, with P = prescale:
  - edge_cnt runs 0..P-1 and wraps.
  - bit_cnt counts bits within the frame and advances when edge_cnt wraps.
- Sampling:
  - rx_s is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, registered at edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: busy=0. rx_s==0 goes to START with edge_cnt=0 and bit_cnt=0 in the same cycle.
  - START: at the decision point, majority=1 means a glitch; return to IDLE with no outputs. Otherwise go to DATA at the edge_cnt wrap.
  - DATA: shift the majority value into the shift register LSB-first. After DATA_WIDTH bits, go to PARITY if parity_en, else STOP, at the wrap.
  - PARITY:
    - Expected parity is XOR(data) XOR parity_type.
    - On mismatch, latch a parity-fail flag.
    - Go to STOP at the wrap.
  - STOP: at the decision point, go to IDLE immediately; do not wait for the end of the bit, so a following start edge is caught. In the next cycle, exactly one of the following applies:
    - stop=1 and no parity fail: p_data <= shift register, data_valid=1.
    - stop=0: stop_error=1 (also parity_error=1 if the parity-fail flag is set); p_data unchanged, data_valid=0.
    - stop=1 with parity fail: parity_error=1; p_data unchanged.
- Pulse widths: data_valid and the error pulses are exactly 1 clk. p_data holds until the next good frame.
- busy: 1 from START entry until the STOP decision.
- Back-to-back frames: a start bit that begins right after the stop bit must be received with no loss.
- Input changes:
  - parity_en and parity_type are captured on leaving IDLE.
  - Changing prescale mid-frame is undefined; it takes effect from the next IDLE.
- Illegal prescale values give undefined output but must not hang the FSM; edge_cnt always wraps at P-1.
- Reset mid-frame: immediate return to reset values; the next complete frame is received normally.
- Break condition (line held low): produces a stop_error, then START is re-entered while the line stays low. No data_valid.

Decomposition:
- Package uart_pkg holds:
  - FSM state encodings (shared style with the transmitter);
  - prescale legal constants PRESCALE_8/16/32;
  - DATA_WIDTH default;
  - function parity_calc(data, type).
- One sub-module, uart_rx_sampler:
  - takes rx_s, edge_cnt and prescale;
  - produces the 3 samples, the majority bit and a sample_done strobe.
- FSM, counters and checks live in uart_rx_core.

Test Plan:
- Clean frame, no parity: prescale=8, parity_en=0, send 0xA5 → p_data=0xA5 with data_valid one cycle, no errors, busy low afterwards.
- Even parity OK: prescale=16, parity_en=1, parity_type=0, send 0x3C with parity bit 0 → data_valid, p_data=0x3C. The same frame with parity bit 1 → parity_error pulse, no data_valid, p_data still 0x3C.
- Stop error: prescale=8, send 0x5A with stop bit 0 → stop_error pulse, data_valid=0, FSM back in IDLE, busy low.
- Glitch rejection: prescale=8, rx_in low for 2 clk then high → no outputs; busy drops at the START decision. A following valid 0x81 frame → p_data=0x81.
- Back-to-back: prescale=32, frames 0x12 then 0xEF with zero idle gap → two data_valid pulses, exactly 10·32 clk apart, with p_data 0x12 then 0xEF.
- Mid-frame reset: assert rst during data bit 3 of 0x77 → all outputs 0, busy=0. The next 0xC3 frame → p_data=0xC3, data_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, prescale constants and parity helper.
package uart_pkg;

    localparam int unsigned UART_DATA_WIDTH = 8;
    localparam int unsigned PRESCALE_W      = 6;
    localparam int unsigned PARITY_MAX_W    = 32;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Expected parity bit: XOR of the data, inverted for odd parity (ptype=1).
    function automatic logic parity_calc(input logic [PARITY_MAX_W-1:0] data, input logic ptype);
        return (^data) ^ ptype;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Mid-bit triple sampler: captures rx_s around the bit centre and votes.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_s,
    input  logic [PRESCALE_W-1:0] i_edge_cnt,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_majority_c,
    output logic                  o_sample_done_c
);

    logic [PRESCALE_W-1:0] w_half;
    logic [2:0]            r_samples;

    assign w_half = i_prescale >> 1;

    // Capture the three samples at half-1, half and half+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_samples <= 3'b111;
        end else begin
            if (i_edge_cnt == PRESCALE_W'(w_half - 6'd1)) r_samples[0] <= i_rx_s;
            if (i_edge_cnt == w_half)                     r_samples[1] <= i_rx_s;
            if (i_edge_cnt == PRESCALE_W'(w_half + 6'd1)) r_samples[2] <= i_rx_s;
        end
    end

    // Vote is stable once all three samples are registered (half+2).
    assign o_majority_c    = (r_samples[0] & r_samples[1]) |
                             (r_samples[0] & r_samples[2]) |
                             (r_samples[1] & r_samples[2]);
    assign o_sample_done_c = (i_edge_cnt == PRESCALE_W'(w_half + 6'd2));

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchroniser, oversampling counters, frame FSM and checks.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_en,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rx_s;
    uart_state_t            r_state;
    logic [PRESCALE_W-1:0]  r_edge_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_par_en;
    logic                   r_par_type;
    logic                   r_par_fail;
    logic                   w_wrap;
    logic                   w_majority;
    logic                   w_sample_done;

    // Synchroniser resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '1;
        else      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_wrap = (r_edge_cnt == PRESCALE_W'(prescale - 6'd1));

    uart_rx_sampler u_sampler (
        .clk             (clk),
        .rst             (rst),
        .i_rx_s          (w_rx_s),
        .i_edge_cnt      (r_edge_cnt),
        .i_prescale      (prescale),
        .o_majority_c    (w_majority),
        .o_sample_done_c (w_sample_done)
    );

    // Frame FSM with counters, shift register, parity check and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_par_fail   <= 1'b0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            r_edge_cnt   <= w_wrap ? '0 : PRESCALE_W'(r_edge_cnt + 6'd1);

            case (r_state)
                IDLE: begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (!w_rx_s) begin
                        r_state    <= START;
                        busy       <= 1'b1;
                        r_par_en   <= parity_en;
                        r_par_type <= parity_type;
                        r_par_fail <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that votes high was a glitch.
                    if (w_sample_done && w_majority) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_sample_done) r_shift <= {w_majority, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= BIT_CNT_W'(r_bit_cnt + 1'b1);
                        end
                    end
                end
                PARITY: begin
                    if (w_sample_done &&
                        (w_majority != parity_calc(PARITY_MAX_W'(r_shift), r_par_type)))
                        r_par_fail <= 1'b1;
                    if (w_wrap) r_state <= STOP;
                end
                STOP: begin
                    // Leave at the decision point so an immediately following start is seen.
                    if (w_sample_done) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (!w_majority) begin
                            stop_error   <= 1'b1;
                            parity_error <= r_par_fail;
                        end else if (r_par_fail) begin
                            parity_error <= 1'b1;
                        end else begin
                            p_data     <= r_shift;
                            data_valid <= 1'b1;
                        end
                    end else if (w_wrap) begin
                        // Only reachable with an illegal prescale; keeps the FSM moving.
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames, parity, stop error, glitch, back-to-back, reset.
module tb_uart_rx_core;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    int cyc          = 0;
    int dv_cnt       = 0;
    int pe_cnt       = 0;
    int se_cnt       = 0;
    int wide_cnt     = 0;
    int last_dv_cyc  = 0;
    int prev_dv_cyc  = 0;
    logic [7:0] last_dv_data = 8'h00;
    logic [7:0] prev_dv_data = 8'h00;
    logic dv_q = 1'b0;
    logic pe_q = 1'b0;
    logic se_q = 1'b0;

    uart_rx_core dut (
        .clk          (clk),
        .rst          (rst),
        .rx_in        (rx_in),
        .prescale     (prescale),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (data_valid) begin
            dv_cnt       <= dv_cnt + 1;
            prev_dv_cyc  <= last_dv_cyc;
            last_dv_cyc  <= cyc;
            prev_dv_data <= last_dv_data;
            last_dv_data <= p_data;
        end
        if (parity_error) pe_cnt <= pe_cnt + 1;
        if (stop_error)   se_cnt <= se_cnt + 1;
        if ((data_valid && dv_q) || (parity_error && pe_q) || (stop_error && se_q))
            wide_cnt <= wide_cnt + 1;
        dv_q <= data_valid;
        pe_q <= parity_error;
        se_q <= stop_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx_in = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                              input logic sbit, input int p);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_p_data"}, 32'(p_data), 32'h00);
        check({tag, "_dv"},     32'(data_valid), 32'h0);
        check({tag, "_pe"},     32'(parity_error), 32'h0);
        check({tag, "_se"},     32'(stop_error), 32'h0);
        check({tag, "_busy"},   32'(busy), 32'h0);
    endtask

    int dv0, pe0, se0;

    initial begin
        rst         = 1'b0;
        rx_in       = 1'b1;
        prescale    = PRESCALE_8;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        idle(10);

        // Clean frame, no parity, prescale 8.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8);
        idle(16);
        check("a5_dv_count", 32'(dv_cnt - dv0), 32'd1);
        check("a5_p_data",   32'(p_data), 32'hA5);
        check("a5_no_pe",    32'(pe_cnt - pe0), 32'd0);
        check("a5_no_se",    32'(se_cnt - se0), 32'd0);
        check("a5_busy",     32'(busy), 32'h0);

        // Even parity, prescale 16: good then bad parity bit.
        prescale  = PRESCALE_16;
        parity_en = 1'b1;
        idle(4);
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        idle(32);
        check("even_ok_dv",     32'(dv_cnt - dv0), 32'd1);
        check("even_ok_p_data", 32'(p_data), 32'h3C);
        check("even_ok_no_pe",  32'(pe_cnt - pe0), 32'd0);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        idle(32);
        check("even_bad_pe",     32'(pe_cnt - pe0), 32'd1);
        check("even_bad_no_dv",  32'(dv_cnt - dv0), 32'd0);
        check("even_bad_no_se",  32'(se_cnt - se0), 32'd0);
        check("even_bad_p_data", 32'(p_data), 32'h3C);

        // Odd parity: 0x3C has four ones, so the parity bit must be 1.
        parity_type = 1'b1;
        idle(4);
        dv0 = dv_cnt; pe0 = pe_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16);
        idle(32);
        check("odd_ok_dv", 32'(dv_cnt - dv0), 32'd1);
        check("odd_ok_pe", 32'(pe_cnt - pe0), 32'd0);

        // Stop error, prescale 8, no parity.
        prescale    = PRESCALE_8;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        idle(4);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8);
        idle(24);
        check("stop_se",     32'(se_cnt - se0), 32'd1);
        check("stop_no_dv",  32'(dv_cnt - dv0), 32'd0);
        check("stop_no_pe",  32'(pe_cnt - pe0), 32'd0);
        check("stop_p_data", 32'(p_data), 32'h3C);
        check("stop_busy",   32'(busy), 32'h0);

        // Glitch: two clocks low is rejected at the start decision.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        drive_bit(1'b0, 2);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'h1);
        repeat (12) @(negedge clk);
        check("glitch_busy_low", 32'(busy), 32'h0);
        check("glitch_no_out", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
        idle(16);
        check("after_glitch_dv",     32'(dv_cnt - dv0), 32'd1);
        check("after_glitch_p_data", 32'(p_data), 32'h81);

        // Back-to-back frames at prescale 32 with no idle gap.
        prescale = PRESCALE_32;
        idle(8);
        dv0 = dv_cnt;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 32);
        send_frame(8'hEF, 1'b0, 1'b0, 1'b1, 32);
        idle(64);
        check("b2b_dv_count", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_first",    32'(prev_dv_data), 32'h12);
        check("b2b_second",   32'(last_dv_data), 32'hEF);
        check("b2b_spacing",  32'(last_dv_cyc - prev_dv_cyc), 32'd320);

        // Reset in the middle of data bit 3 of 0x77.
        prescale = PRESCALE_8;
        idle(8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 4);
        rst   = 1'b0;
        rx_in = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        idle(16);
        dv0 = dv_cnt; se0 = se_cnt;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8);
        idle(16);
        check("post_reset_dv",     32'(dv_cnt - dv0), 32'd1);
        check("post_reset_p_data", 32'(p_data), 32'hC3);
        check("post_reset_no_se",  32'(se_cnt - se0), 32'd0);

        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
